// File: rtl/pico_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pico_step_ctrl
//  Description : Execution sequencer for the picoMIPS core. Synchronises and
//                debounces the "data ready" switch (sw8), captures the operand
//                switches (sws) on each completed press/release, and gates the
//                PC increment and register-file write so that instructions
//                needing switch input stall until the operator has toggled sw8.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1   system clock, rising edge
//    reset      in   1   synchronous, active-low reset
//    sw8        in   1   raw asynchronous "data ready" switch (bouncing)
//    sws        in   n   raw operand switches
//    dec_write  in   1   decoder register-write request
//    dec_wait   in   1   current instruction takes its operand from switches
//    dec_halt   in   1   current instruction is HALT
//    pc_incr    out  1   increment enable to the program counter
//    reg_write  out  1   gated register-file write enable
//    sws_q      out  n   captured switch operand
//    state      out  2   IDLE=00, RUN=01, WAIT_SW=10, HALT=11
//    instr_cnt  out  16  retired-instruction count (wraps)
// ============================================================================
module pico_step_ctrl #(
  parameter int n          = 8,
  parameter int DEB_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sw8,
  input  logic [n-1:0] sws,
  input  logic         dec_write,
  input  logic         dec_wait,
  input  logic         dec_halt,
  output logic         pc_incr,
  output logic         reg_write,
  output logic [n-1:0] sws_q,
  output logic [1:0]   state,
  output logic [15:0]  instr_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_WAIT_SW = 2'b10,
    ST_HALT    = 2'b11
  } state_t;

  // Terminal count of the debounce counter: DEB_CYCLES consecutive
  // mismatching samples are needed before the debounced level follows.
  localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);

  state_t        state_q,     state_d;
  logic          sync1_q,     sync1_d;
  logic          sync2_q,     sync2_d;
  logic          sw_db_q,     sw_db_d;
  logic [15:0]   cnt_q,       cnt_d;
  logic          sw_evt_q,    sw_evt_d;
  logic [n-1:0]  sws_d;
  logic [15:0]   instr_cnt_q, instr_cnt_d;

  // --------------------------------------------------------------------------
  // Synchroniser, debouncer and release-event capture
  // --------------------------------------------------------------------------
  always_comb begin
    sync1_d  = sw8;
    sync2_d  = sync1_q;
    sw_db_d  = sw_db_q;
    cnt_d    = '0;
    sw_evt_d = 1'b0;
    sws_d    = sws_q;

    // Any sample matching the debounced level restarts the count (cnt_d
    // defaults to zero), so a bounce anywhere in the window restarts latency.
    if (sync2_q != sw_db_q) begin
      if (cnt_q == DEB_LAST) begin
        sw_db_d = sync2_q;
        // Only the debounced 1->0 transition (switch release) is an event;
        // the operand is latched on that very edge.
        if (sw_db_q) begin
          sw_evt_d = 1'b1;
          sws_d    = sws;
        end
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer FSM: next state and combinational gating outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    pc_incr   = 1'b0;
    reg_write = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (sw_evt_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        // HALT takes priority over a switch-operand stall.
        if (dec_halt) begin
          state_d = ST_HALT;
        end else if (dec_wait) begin
          state_d = ST_WAIT_SW;
        end else begin
          pc_incr   = 1'b1;
          reg_write = dec_write;
        end
      end
      ST_WAIT_SW: begin
        // The stalled instruction retires in the event cycle itself, using
        // the operand that was captured on the same edge.
        if (sw_evt_q) begin
          pc_incr   = 1'b1;
          reg_write = dec_write;
          state_d   = ST_RUN;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    instr_cnt_d = pc_incr ? (instr_cnt_q + 16'd1) : instr_cnt_q;
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sw_db_q     <= 1'b0;
      cnt_q       <= '0;
      sw_evt_q    <= 1'b0;
      sws_q       <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sw_db_q     <= sw_db_d;
      cnt_q       <= cnt_d;
      sw_evt_q    <= sw_evt_d;
      sws_q       <= sws_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign state     = state_q;
  assign instr_cnt = instr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pico_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pico_step_ctrl
//  Description : Self-checking bench for pico_step_ctrl with a cycle-level
//                behavioural reference model and a retirement scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pico_step_ctrl;

  localparam int DEB = 4;

  localparam logic [1:0] E_IDLE = 2'b00;
  localparam logic [1:0] E_RUN  = 2'b01;
  localparam logic [1:0] E_WAIT = 2'b10;
  localparam logic [1:0] E_HALT = 2'b11;

  logic        clk;
  logic        reset;
  logic        sw8;
  logic [7:0]  sws;
  logic        dec_write;
  logic        dec_wait;
  logic        dec_halt;
  logic        pc_incr;
  logic        reg_write;
  logic [7:0]  sws_q;
  logic [1:0]  state;
  logic [15:0] instr_cnt;

  pico_step_ctrl #(
    .n          (8),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sw8       (sw8),
    .sws       (sws),
    .dec_write (dec_write),
    .dec_wait  (dec_wait),
    .dec_halt  (dec_halt),
    .pc_incr   (pc_incr),
    .reg_write (reg_write),
    .sws_q     (sws_q),
    .state     (state),
    .instr_cnt (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Expected retirement record: one per predicted pc_incr cycle.
  typedef struct packed {
    logic        wr;
    logic [7:0]  swsq;
    logic [15:0] cnt;
  } ret_t;

  ret_t exp_q[$];

  // Reference model state, describing the registered values during the
  // current cycle (i.e. after the most recent rising edge).
  logic [1:0]  m_state;
  bit          m_db;
  bit          m_evt;
  logic [7:0]  m_swsq;
  logic [15:0] m_cnt;
  bit          m_valid = 1'b0;
  // History of sw8 as sampled at each edge, newest first. The synchronised
  // level seen just before an edge is the sample taken two edges earlier.
  bit          raw[$];

  // --------------------------------------------------------------------------
  // Reference model: inputs are stable between posedge+1 and the next
  // posedge, so evaluating at the falling edge sees what the next edge sees.
  // --------------------------------------------------------------------------
  always @(negedge clk) begin : model
    bit         e_inc;
    bit         e_wr;
    bit         all_diff;
    bit         fell;
    logic [1:0] nxt;

    case (m_state)
      E_RUN:   e_inc = !dec_halt && !dec_wait;
      E_WAIT:  e_inc = m_evt;
      default: e_inc = 1'b0;
    endcase
    e_wr = e_inc && dec_write;

    if (m_valid) begin
      chk("state", state, m_state);
      chk("sws_q", sws_q, m_swsq);
      chk("instr_cnt", instr_cnt, m_cnt);
      if (reset) begin
        chk("pc_incr", pc_incr, e_inc);
        if (e_inc) exp_q.push_back('{wr: e_wr, swsq: m_swsq, cnt: m_cnt});
        else       chk("reg_write_idle", reg_write, 1'b0);
      end
    end

    if (!reset) begin
      m_state = E_IDLE;
      m_db    = 1'b0;
      m_evt   = 1'b0;
      m_swsq  = 8'h00;
      m_cnt   = 16'h0000;
      raw.delete();
      repeat (DEB + 2) raw.push_back(1'b0);
      m_valid = 1'b1;
    end else if (m_valid) begin
      nxt = m_state;
      case (m_state)
        E_IDLE: if (m_evt) nxt = E_RUN;
        E_RUN: begin
          if (dec_halt)      nxt = E_HALT;
          else if (dec_wait) nxt = E_WAIT;
        end
        E_WAIT: if (m_evt) nxt = E_RUN;
        default: nxt = m_state;
      endcase
      if (e_inc) m_cnt = m_cnt + 16'd1;

      // Debounced level follows once the last DEB pre-edge synchronised
      // samples all disagree with it.
      all_diff = 1'b1;
      for (int i = 0; i < DEB; i++)
        if (raw[1 + i] == m_db) all_diff = 1'b0;
      fell = all_diff && m_db;
      if (fell)     m_swsq = sws;
      if (all_diff) m_db   = !m_db;
      m_evt = fell;
      raw.push_front(sw8);
      void'(raw.pop_back());
      m_state = nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Monitor: every DUT retirement is matched against the scoreboard.
  // --------------------------------------------------------------------------
  always @(negedge clk) begin : monitor
    ret_t e;
    #1;
    if (m_valid && reset && pc_incr) begin
      chk("retire_expected", (exp_q.size() > 0), 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ret_reg_write", reg_write, e.wr);
        chk("ret_sws_q", sws_q, e.swsq);
        chk("ret_instr_cnt", instr_cnt, e.cnt);
      end
    end
  end

  task automatic hold(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_release(input int hi, input int lo);
    sw8 = 1'b1;
    hold(hi);
    sw8 = 1'b0;
    hold(lo);
  endtask

  initial begin
    reset     = 1'b0;
    sw8       = 1'b1;
    sws       = 8'h00;
    dec_write = 1'b0;
    dec_wait  = 1'b0;
    dec_halt  = 1'b0;

    // Reset with sw8 held high, then debounce through a bouncing release.
    hold(2);
    reset = 1'b1;
    hold(10);
    for (int i = 0; i < 10; i++) begin
      sw8 = (i % 2 == 0) ? 1'b0 : 1'b1;
      hold(2);
    end
    sw8 = 1'b0;
    hold(12);

    // Run with writes.
    dec_write = 1'b1;
    hold(5);

    // Switch-operand stall and capture.
    dec_wait = 1'b1;
    hold(1);
    dec_wait = 1'b0;
    sws      = 8'hA5;
    hold(3);
    press_release(8, 8);
    sws = 8'h3C;
    hold(4);

    // HALT has priority; a later press is ignored.
    dec_wait = 1'b1;
    dec_halt = 1'b1;
    hold(1);
    dec_wait = 1'b0;
    dec_halt = 1'b0;
    press_release(8, 8);

    // Reset during WAIT_SW.
    reset = 1'b0;
    hold(1);
    reset = 1'b1;
    press_release(8, 8);
    dec_wait = 1'b1;
    hold(1);
    dec_wait = 1'b0;
    hold(3);
    reset = 1'b0;
    hold(1);
    reset = 1'b1;
    hold(3);

    // Randomised episodes.
    for (int ep = 0; ep < 6; ep++) begin
      reset = 1'b0;
      hold(1);
      reset = 1'b1;
      for (int c = 0; c < 300; c++) begin
        dec_write = 1'($urandom);
        dec_wait  = ($urandom_range(0, 3) == 0);
        dec_halt  = ($urandom_range(0, 63) == 0);
        sws       = 8'($urandom);
        if ($urandom_range(0, 7) == 0) sw8 = ~sw8;
        hold(1);
      end
    end

    // Long run through the 16-bit counter wrap.
    reset     = 1'b0;
    dec_wait  = 1'b0;
    dec_halt  = 1'b0;
    dec_write = 1'b0;
    hold(1);
    reset = 1'b1;
    press_release(8, 8);
    for (int c = 0; c < 65545; c++) begin
      dec_write = 1'($urandom);
      hold(1);
    end
    dec_write = 1'b0;
    hold(2);
    @(negedge clk);
    #2;
    chk("retire_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
